// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, IF/ID record and PC helpers.
// Used by the fetch stage and reused by the decode stage.
package core_pkg;

    localparam int               INSTR_W           = 32;
    localparam logic [31:0]      PC_INC            = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc4;
        logic               valid;
    } if_id_t;

    // A byte address is fetchable when it lies below the end of instruction memory.
    function automatic logic pc_in_range(input logic [31:0] pc, input int unsigned imem_words);
        return pc < (imem_words << 2);
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register with next-PC selection: redirect beats advance,
// and redirect targets are forced to word alignment.
module pc_reg
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic        i_advance,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_target
);

    logic [31:0] r_pc;

    assign o_target   = i_target & ~32'h0000_0003;
    assign o_pc_plus4 = r_pc + PC_INC;
    assign o_pc       = r_pc;

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= o_target;
        end else if (i_advance) begin
            r_pc <= o_pc_plus4;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and
// captures the result into the IF/ID register; halts when the PC leaves memory.
module instruction_fetch
    import core_pkg::*;
#(
    parameter logic [31:0]        RESET_PC   = 32'h0000_0000,
    parameter int unsigned        IMEM_WORDS = 20,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    output logic [31:0]        o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_redirect,
    input  logic [31:0]        i_redirect_pc,
    output logic [INSTR_W-1:0] o_if_id_instr,
    output logic [31:0]        o_if_id_pc4,
    output logic               o_if_id_valid,
    output logic               o_halted,
    output logic [15:0]        o_fetch_count
);

    fetch_state_t r_state;
    if_id_t       r_if_id;
    logic         r_halted;
    logic [15:0]  r_fetch_count;

    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_pc_in_range;
    logic        w_target_in_range;
    logic        w_take_redirect;
    logic        w_advance;
    logic        w_fetch_ok;

    assign w_pc_in_range     = pc_in_range(w_pc, IMEM_WORDS);
    assign w_target_in_range = pc_in_range(w_target, IMEM_WORDS);

    // Once halted, only a redirect that lands back inside memory is honoured.
    assign w_take_redirect = i_redirect && ((r_state != HALT) || w_target_in_range);
    assign w_fetch_ok      = (r_state == RUN) && w_pc_in_range;
    assign w_advance       = w_fetch_ok && !i_stall;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_take_redirect),
        .i_advance  (w_advance),
        .i_target   (i_redirect_pc),
        .o_pc       (w_pc),
        .o_pc_plus4 (w_pc_plus4),
        .o_target   (w_target)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= BOOT;
            r_halted      <= 1'b0;
            r_if_id.instr <= NOP_INSTR;
            r_if_id.pc4   <= 32'h0000_0000;
            r_if_id.valid <= 1'b0;
            r_fetch_count <= 16'h0000;
        end else begin
            unique case (r_state)
                BOOT: r_state <= RUN;
                RUN: begin
                    if (!i_redirect && !w_pc_in_range) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (w_take_redirect) begin
                        r_state  <= RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: r_state <= BOOT;
            endcase

            // Bubbles keep pc4 so the decode stage always sees a stable value.
            if (i_flush || i_redirect) begin
                r_if_id.instr <= NOP_INSTR;
                r_if_id.valid <= 1'b0;
            end else if (i_stall) begin
                r_if_id <= r_if_id;
            end else if (w_fetch_ok) begin
                r_if_id.instr <= i_imem_rdata;
                r_if_id.pc4   <= w_pc_plus4;
                r_if_id.valid <= 1'b1;
                r_fetch_count <= r_fetch_count + 16'd1;
            end else begin
                r_if_id.instr <= NOP_INSTR;
                r_if_id.valid <= 1'b0;
            end
        end
    end

    assign o_imem_addr   = w_pc;
    assign o_if_id_instr = r_if_id.instr;
    assign o_if_id_pc4   = r_if_id.pc4;
    assign o_if_id_valid = r_if_id.valid;
    assign o_halted      = r_halted;
    assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand-written halt/reset
// sequences, then randomized traffic against a behavioural fetch model.
module tb_instruction_fetch;

    localparam int          IMEM_WORDS = 20;
    localparam logic [31:0] NOP        = 32'h0000_0000;
    localparam logic [31:0] MEM_END    = 32'd80;

    logic        clk;
    logic        i_reset;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic        i_stall;
    logic        i_flush;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_if_id_instr;
    logic [31:0] o_if_id_pc4;
    logic        o_if_id_valid;
    logic        o_halted;
    logic [15:0] o_fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [IMEM_WORDS];

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (IMEM_WORDS),
        .NOP_INSTR  (NOP)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .o_imem_addr   (o_imem_addr),
        .i_imem_rdata  (i_imem_rdata),
        .i_stall       (i_stall),
        .i_flush       (i_flush),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_if_id_instr (o_if_id_instr),
        .o_if_id_pc4   (o_if_id_pc4),
        .o_if_id_valid (o_if_id_valid),
        .o_halted      (o_halted),
        .o_fetch_count (o_fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory; garbage outside the populated range.
    always_comb begin
        i_imem_rdata = 32'hDEAD_BEEF;
        if (o_imem_addr < MEM_END) i_imem_rdata = mem[o_imem_addr[6:2]];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid, input logic halted,
                             input logic [15:0] count);
        check({tag, ".addr"},   o_imem_addr,           addr);
        check({tag, ".instr"},  o_if_id_instr,         instr);
        check({tag, ".pc4"},    o_if_id_pc4,           pc4);
        check({tag, ".valid"},  32'(o_if_id_valid),    32'(valid));
        check({tag, ".halted"}, 32'(o_halted),         32'(halted));
        check({tag, ".count"},  32'(o_fetch_count),    32'(count));
    endtask

    task automatic drive(input logic rst, input logic st, input logic fl, input logic rd,
                         input logic [31:0] rpc);
        @(negedge clk);
        i_reset       = rst;
        i_stall       = st;
        i_flush       = fl;
        i_redirect    = rd;
        i_redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: what the fetch stage should look like after each edge.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_booting, m_halted;
    logic [15:0] m_count;

    task automatic model_reset();
        m_pc = 0; m_instr = NOP; m_pc4 = 0; m_valid = 0;
        m_booting = 1; m_halted = 0; m_count = 0;
    endtask

    task automatic model_step(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
        logic [31:0] tgt;
        logic        pc_ok, tgt_ok, fetching;
        tgt      = {rpc[31:2], 2'b00};
        pc_ok    = m_pc < MEM_END;
        tgt_ok   = tgt < MEM_END;
        fetching = !m_booting && !m_halted && pc_ok;
        if (fl || rd) begin
            m_instr = NOP; m_valid = 0;
        end else if (st) begin
            // hold everything
        end else if (fetching) begin
            m_instr = mem[m_pc / 4];
            m_pc4   = m_pc + 4;
            m_valid = 1;
            m_count = m_count + 1;
        end else begin
            m_instr = NOP; m_valid = 0;
        end
        if (m_halted) begin
            if (rd && tgt_ok) begin
                m_pc = tgt; m_halted = 0;
            end
        end else if (m_booting) begin
            if (rd) m_pc = tgt;
            m_booting = 0;
        end else if (rd) begin
            m_pc = tgt;
        end else if (!pc_ok) begin
            m_halted = 1;
        end else if (!st) begin
            m_pc = m_pc + 4;
        end
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
        logic [15:0] count;
    } vec_t;

    vec_t vecs[14];

    initial begin
        mem[0] = 32'h8C01_0008;
        mem[1] = 32'hAC01_0010;
        mem[2] = 32'h8C20_0001;
        for (int i = 3; i < IMEM_WORDS; i++) mem[i] = 32'h2000_0000 | 32'(i);

        i_reset = 1; i_stall = 0; i_flush = 0; i_redirect = 0; i_redirect_pc = 0;

        //            st fl rd rpc     addr   instr          pc4  v  h  cnt
        vecs[0]  = '{0, 0, 0, 32'd0,  32'd0,  NOP,           0,   0, 0, 0}; // BOOT
        vecs[1]  = '{0, 0, 0, 32'd0,  32'd4,  32'h8C01_0008, 4,   1, 0, 1};
        vecs[2]  = '{0, 0, 0, 32'd0,  32'd8,  32'hAC01_0010, 8,   1, 0, 2};
        vecs[3]  = '{1, 0, 0, 32'd0,  32'd8,  32'hAC01_0010, 8,   1, 0, 2};
        vecs[4]  = '{1, 0, 0, 32'd0,  32'd8,  32'hAC01_0010, 8,   1, 0, 2};
        vecs[5]  = '{0, 0, 0, 32'd0,  32'd12, 32'h8C20_0001, 12,  1, 0, 3};
        vecs[6]  = '{0, 0, 1, 32'd7,  32'd4,  NOP,           12,  0, 0, 3};
        vecs[7]  = '{0, 0, 0, 32'd0,  32'd8,  32'hAC01_0010, 8,   1, 0, 4};
        vecs[8]  = '{0, 0, 1, 32'd4,  32'd4,  NOP,           8,   0, 0, 4};
        vecs[9]  = '{0, 1, 0, 32'd0,  32'd8,  NOP,           8,   0, 0, 4};
        vecs[10] = '{0, 0, 0, 32'd0,  32'd12, 32'h8C20_0001, 12,  1, 0, 5};
        vecs[11] = '{1, 1, 0, 32'd0,  32'd12, NOP,           12,  0, 0, 5};
        vecs[12] = '{1, 0, 1, 32'd2,  32'd0,  NOP,           12,  0, 0, 5};
        vecs[13] = '{0, 0, 0, 32'd0,  32'd4,  32'h8C01_0008, 4,   1, 0, 6};

        drive(1, 0, 0, 0, 0);
        check_all("reset", 0, NOP, 0, 0, 0, 0);

        for (int v = 0; v < 14; v++) begin
            drive(0, vecs[v].stall, vecs[v].flush, vecs[v].redir, vecs[v].rpc);
            check_all($sformatf("vec%0d", v), vecs[v].addr, vecs[v].instr, vecs[v].pc4,
                      vecs[v].valid, vecs[v].halted, vecs[v].count);
        end

        // Run off the end of memory, sit in HALT, then recover by redirect.
        drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 21; k++) drive(0, 0, 0, 0, 0);
        check_all("last_word", 80, 32'h2000_0013, 80, 1, 0, 20);
        drive(0, 0, 0, 0, 0);
        check_all("halt_enter", 80, NOP, 80, 0, 1, 20);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check_all("halt_hold", 80, NOP, 80, 0, 1, 20);
        drive(0, 0, 0, 1, 32'd100);
        check_all("halt_bad_redir", 80, NOP, 80, 0, 1, 20);
        drive(0, 0, 0, 1, 32'd0);
        check_all("halt_exit", 0, NOP, 80, 0, 0, 20);
        drive(0, 0, 0, 0, 0);
        check_all("resume", 4, 32'h8C01_0008, 4, 1, 0, 21);

        // Reset must dominate a simultaneous stall and redirect.
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 32'd40);
        check_all("mid_reset", 0, NOP, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check_all("mid_boot", 0, NOP, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check_all("mid_first", 4, 32'h8C01_0008, 4, 1, 0, 1);

        // Randomized traffic against the model.
        drive(1, 0, 0, 0, 0);
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        rst, st, fl, rd;
            logic [31:0] rpc;
            rst = ($urandom_range(0, 199) == 0);
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            rd  = ($urandom_range(0, 11) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 100));
            drive(rst, st, fl, rd, rpc);
            if (rst) model_reset();
            else     model_step(st, fl, rd, rpc);
            check_all($sformatf("rand%0d", n), m_pc, m_instr, m_pc4, m_valid, m_halted, m_count);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage of the 32-bit MIPS-style core. It owns the program counter and drives the word-addressed instruction memory address. The memory's combinational read data is captured into the IF/ID pipeline register (instruction, PC+4, valid). The stage supports stall, flush, branch/jump redirect, and halts cleanly when the PC runs past the end of instruction memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
IMEM_WORDS, 20, number of valid instruction words; byte addresses >= IMEM_WORDS*4 are out of range
NOP_INSTR, 32'h0000_0000, instruction inserted into IF/ID on bubbles

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
imem_addr  output  32  byte address to instruction memory (equals current PC)
imem_rdata  input  32  instruction word returned combinationally for imem_addr
stall  input  1  hold PC and IF/ID contents (hazard unit)
flush  input  1  squash the IF/ID register (insert bubble)
redirect  input  1  take redirect_pc as next PC (branch taken or jump)
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced to 0)
if_id_instr  output  32  registered instruction
if_id_pc4  output  32  registered PC+4 of that instruction
if_id_valid  output  1  IF/ID holds a real instruction
halted  output  1  fetch has stopped (PC out of range)
fetch_count  output  16  number of instructions delivered valid into IF/ID

Behaviour:
- Reset (sync, wins over everything): pc=RESET_PC, state=BOOT, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, halted=0, fetch_count=0.
- imem_addr = pc, combinationally; read data is consumed in the same cycle.
- States:
  - BOOT: one cycle with no capture; next state RUN. pc is unchanged unless redirect is asserted.
  - RUN: normal fetch.
  - HALT: pc is frozen, halted=1, and every capture is a bubble. Only reset leaves HALT, or a redirect to an in-range target, which returns to RUN.
- In range means pc < IMEM_WORDS*4. In RUN, if pc is out of range at the edge, go to HALT and capture a bubble, not the memory data.
- Next-PC priority, per edge in RUN/BOOT:
  1. reset
  2. redirect: pc <= {redirect_pc[31:2],2'b00}
  3. stall: pc held
  4. otherwise pc <= pc+4
- A redirect during stall still updates pc.
- IF/ID priority, per edge:
  1. reset
  2. flush or redirect: bubble (valid=0, instr=NOP_INSTR, pc4 unchanged)
  3. stall: hold all fields
  4. RUN and pc in range: instr <= imem_rdata, pc4 <= pc+4, valid <= 1
  5. otherwise: bubble
- Latency: the instruction at PC appears on if_id_instr one edge after imem_addr=PC, when not stalled.
- fetch_count increments by 1 on each edge where IF/ID is loaded with valid=1. It wraps from 16'hFFFF to 0. It holds on stall, bubble, and HALT.
- pc+4 uses a 32-bit add and wraps modulo 2^32. A wrapped PC is out of range unless IMEM_WORDS covers it.
- Simultaneous stall+flush: flush wins for IF/ID; the PC is held.

Decomposition:
- Shared package (core_pkg): fetch_state_t enum {BOOT, RUN, HALT}; localparams INSTR_W=32, PC_INC=4; NOP_INSTR default value; if_id_t struct {instr, pc4, valid}, reused by the decode stage.
- One natural sub-module: pc_reg, holding the PC register with next-PC mux (redirect/stall/increment and alignment). The IF/ID register and FSM stay in instruction_fetch.

Test Plan:
- Reset then free-run against a memory holding word0=32'h8C010008, word1=32'hAC010010, word2=32'h8C200001 → imem_addr 0,0,4,8 on successive cycles. IF/ID shows 8C010008/pc4=4, then AC010010/8, then 8C200001/12, all valid. fetch_count=3.
- Stall asserted for 2 cycles while imem_addr=8 → imem_addr stays 8. IF/ID holds AC010010/pc4=8, valid, and fetch_count is unchanged. After release, 8C200001 is captured.
- Redirect with redirect_pc=32'h0000_0007 while pc=12 → next imem_addr=4 and IF/ID is a bubble (valid=0). The following edge captures AC010010/pc4=8.
- Flush alone at pc=4 → IF/ID valid=0 with instr=NOP_INSTR, and pc advances to 8.
- Free-run past word 19 → at imem_addr=80, halted=1 next edge; imem_addr stays 80 and valid stays 0. A redirect to 0 clears halted and resumes fetching word0.
- Reset asserted mid-run with stall=1 and redirect=1 → all outputs return to reset values and the state is BOOT; the first valid capture is word0.
